// File: rtl/accel_pkg.sv
// Shared types for the accelerator control path: packet/command layouts, opcodes,
// dispatcher states and the control-packet decoder used by every decoder instance.
package accel_pkg;

  localparam int UNIT_COUNT    = 256;
  localparam int UNIT_ID_WIDTH = 8;

  typedef enum logic [1:0] {OP_NOP, OP_COMPUTE, OP_LOAD, OP_STORE} op_e;
  typedef enum logic [1:0] {COMP_ADD, COMP_MUL, COMP_MAC, COMP_CMP} comp_e;

  typedef enum logic [1:0] {IDLE, DECODE, WAIT_UNIT, ISSUE} disp_state_e;

  // 'config' is a reserved word, so the configuration byte is named cfg.
  typedef struct packed {
    logic [UNIT_ID_WIDTH-1:0] unit_id;
    logic [7:0]               ctrl;
    logic [7:0]               cfg;
  } ctrl_packet_t;

  typedef struct packed {
    logic [UNIT_ID_WIDTH-1:0] unit_id;
    op_e                      op_code;
    comp_e                    comp_type;
    logic [3:0]               addr;
    logic                     valid;
    logic [2:0]               size;
  } decoded_ctrl_t;

  function automatic decoded_ctrl_t decode_ctrl(input ctrl_packet_t p);
    decoded_ctrl_t d;
    d.unit_id   = p.unit_id;
    d.op_code   = op_e'(p.ctrl[5:4]);
    d.comp_type = comp_e'(p.ctrl[3:2]);
    d.addr      = p.cfg[7:4];
    d.size      = p.cfg[2:0];
    d.valid     = (d.op_code != OP_NOP);
    return d;
  endfunction

endpackage

// File: rtl/unit_scoreboard.sv
// Per-unit busy bits: set on issue, cleared on done; set wins over a same-cycle clear.
// Flags a done for an idle or out-of-range unit as spurious (combinational pulse).
module unit_scoreboard
  import accel_pkg::*;
#(
  parameter int NUM_UNITS = UNIT_COUNT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_vld_i,
  input  logic [UNIT_ID_WIDTH-1:0] set_id_i,
  input  logic                     done_vld_i,
  input  logic [UNIT_ID_WIDTH-1:0] done_id_i,
  output logic [NUM_UNITS-1:0]     busy_o,
  output logic                     spurious_o
);

  logic [NUM_UNITS-1:0] busy_q, busy_d;
  logic                 done_hit;

  always_comb begin
    busy_d     = busy_q;
    done_hit   = 1'b0;
    spurious_o = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (done_vld_i && done_id_i == UNIT_ID_WIDTH'(i)) begin
        done_hit = 1'b1;
        if (busy_q[i]) busy_d[i] = 1'b0;
        else           spurious_o = 1'b1;
      end
    end
    if (done_vld_i && !done_hit) spurious_o = 1'b1;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (set_vld_i && set_id_i == UNIT_ID_WIDTH'(i)) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/accel_dispatcher.sv
// Single-issue dispatcher: latch packet, decode, wait for target unit idle, issue.
// Min 3 cycles/packet (cmd_valid earliest 2 cycles after accept); cmd held until cmd_ready.
module accel_dispatcher
  import accel_pkg::*;
#(
  parameter int NUM_UNITS = UNIT_COUNT,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pkt_valid,
  output logic                          pkt_ready,
  input  logic [$bits(ctrl_packet_t)-1:0]  pkt,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [$bits(decoded_ctrl_t)-1:0] cmd,
  input  logic                          done_valid,
  input  logic [UNIT_ID_WIDTH-1:0]      done_id,
  output logic [NUM_UNITS-1:0]          busy_map,
  output logic [CNT_WIDTH-1:0]          issue_cnt,
  output logic                          err_bad_unit,
  output logic                          err_spurious,
  input  logic                          err_clr
);

  disp_state_e          state_q, state_d;
  ctrl_packet_t         pkt_q, pkt_d;
  decoded_ctrl_t        cmd_q, cmd_d, dec;
  logic                 cmd_vld_q, cmd_vld_d;
  logic                 pkt_rdy_q, pkt_rdy_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_bad_q, err_bad_d;
  logic                 err_spur_q, err_spur_d;
  logic                 bad_set, issue_set, spurious;
  logic                 tgt_legal, tgt_busy;

  assign dec = decode_ctrl(pkt_q);

  // Legality and busy lookup by match, so no out-of-range index is ever formed.
  always_comb begin
    tgt_legal = 1'b0;
    tgt_busy  = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (dec.unit_id == UNIT_ID_WIDTH'(i)) begin
        tgt_legal = 1'b1;
        tgt_busy  = busy_map[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    cmd_d     = cmd_q;
    cmd_vld_d = cmd_vld_q;
    cnt_d     = cnt_q;
    bad_set   = 1'b0;
    issue_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (pkt_valid && pkt_rdy_q) begin
          pkt_d   = ctrl_packet_t'(pkt);
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (dec.op_code == OP_NOP) begin
          state_d = IDLE;
        end else if (!tgt_legal) begin
          bad_set = 1'b1;
          state_d = IDLE;
        end else if (tgt_busy) begin
          state_d = WAIT_UNIT;
        end else begin
          cmd_d     = dec;
          cmd_vld_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      WAIT_UNIT: begin
        if (!tgt_busy) begin
          cmd_d     = dec;
          cmd_vld_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          issue_set = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          cmd_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pkt_rdy_d  = (state_d == IDLE);
    err_bad_d  = bad_set  | (err_bad_q  & ~err_clr);
    err_spur_d = spurious | (err_spur_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pkt_q      <= '0;
      cmd_q      <= '0;
      cmd_vld_q  <= 1'b0;
      pkt_rdy_q  <= 1'b0;
      cnt_q      <= '0;
      err_bad_q  <= 1'b0;
      err_spur_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      cmd_q      <= cmd_d;
      cmd_vld_q  <= cmd_vld_d;
      pkt_rdy_q  <= pkt_rdy_d;
      cnt_q      <= cnt_d;
      err_bad_q  <= err_bad_d;
      err_spur_q <= err_spur_d;
    end
  end

  unit_scoreboard #(.NUM_UNITS(NUM_UNITS)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_vld_i  (issue_set),
    .set_id_i   (cmd_q.unit_id),
    .done_vld_i (done_valid),
    .done_id_i  (done_id),
    .busy_o     (busy_map),
    .spurious_o (spurious)
  );

  assign pkt_ready    = pkt_rdy_q;
  assign cmd_valid    = cmd_vld_q;
  assign cmd          = cmd_q;
  assign issue_cnt    = cnt_q;
  assign err_bad_unit = err_bad_q;
  assign err_spurious = err_spur_q;

endmodule

// File: tb/tb_accel_dispatcher.sv
// Bench for accel_dispatcher with 16 populated units: vector table plus hand sequences;
// issued commands are checked against a queue of expected commands.
module tb_accel_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [23:0] pkt = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [19:0] cmd;
  logic        done_valid = 1'b0;
  logic [7:0]  done_id = '0;
  logic [15:0] busy_map;
  logic [15:0] issue_cnt;
  logic        err_bad_unit;
  logic        err_spurious;
  logic        err_clr = 1'b0;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  logic [19:0] exp_q[$];

  accel_dispatcher #(.NUM_UNITS(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt(pkt),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .done_valid(done_valid), .done_id(done_id),
    .busy_map(busy_map), .issue_cnt(issue_cnt),
    .err_bad_unit(err_bad_unit), .err_spurious(err_spurious), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake must match the oldest expected command.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got %0h expected none", cmd);
      end else begin
        check("sb_cmd", 32'(cmd), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [23:0] p);
    int n = 0;
    while (!pkt_ready && n < 20) begin
      step();
      n++;
    end
    check("pkt_ready_wait", 32'(pkt_ready), 32'(1));
    pkt_valid = 1'b1;
    pkt = p;
    step();
    pkt_valid = 1'b0;
  endtask

  task automatic done_pulse(input logic [7:0] id);
    done_valid = 1'b1;
    done_id = id;
    step();
    done_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  typedef struct {
    logic [23:0] p;
    logic        exp_issue;
    logic [19:0] exp_cmd;
    logic        exp_bad;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] uid;

    vecs[0] = '{24'h05_14_35, 1'b1, 20'h0553D, 1'b0};  // unit 5 COMPUTE MUL
    vecs[1] = '{24'h03_0C_FF, 1'b0, 20'h00000, 1'b0};  // NOP
    vecs[2] = '{24'h0C_E3_A8, 1'b1, 20'h0C8A8, 1'b0};  // LOAD ADD, reserved bits set
    vecs[3] = '{24'h14_30_11, 1'b0, 20'h00000, 1'b1};  // unit 20 illegal
    vecs[4] = '{24'h00_38_7F, 1'b1, 20'h00E7F, 1'b0};  // unit 0 STORE MAC
    vecs[5] = '{24'h0F_1C_02, 1'b1, 20'h0F70A, 1'b0};  // unit 15 (last legal)
    vecs[6] = '{24'h10_14_00, 1'b0, 20'h00000, 1'b1};  // unit 16 (first illegal)
    vecs[7] = '{24'hFF_00_00, 1'b0, 20'h00000, 1'b0};  // NOP to illegal unit

    // Reset state
    step();
    step();
    check("rst_pkt_ready", 32'(pkt_ready), 32'(0));
    check("rst_cmd_valid", 32'(cmd_valid), 32'(0));
    check("rst_busy", 32'(busy_map), 32'(0));
    check("rst_cnt", 32'(issue_cnt), 32'(0));
    rst_n = 1'b1;
    step();
    check("post_rst_pkt_ready", 32'(pkt_ready), 32'(1));

    cmd_ready = 1'b1;
    foreach (vecs[k]) begin
      uid = vecs[k].p[23:16];
      if (vecs[k].exp_issue) exp_q.push_back(vecs[k].exp_cmd);
      send(vecs[k].p);
      check("vec_decode_no_vld", 32'(cmd_valid), 32'(0));
      step();
      check("vec_cmd_valid", 32'(cmd_valid), 32'(vecs[k].exp_issue));
      if (vecs[k].exp_issue) begin
        check("vec_cmd", 32'(cmd), 32'(vecs[k].exp_cmd));
        step();
        exp_cnt++;
        check("vec_cnt", 32'(issue_cnt), 32'(exp_cnt));
        check("vec_busy_set", 32'(busy_map), 32'(16'd1 << uid[3:0]));
        done_pulse(uid);
        check("vec_busy_clr", 32'(busy_map), 32'(0));
      end else begin
        check("vec_pkt_ready", 32'(pkt_ready), 32'(1));
        check("vec_cnt_hold", 32'(issue_cnt), 32'(exp_cnt));
        check("vec_err_bad", 32'(err_bad_unit), 32'(vecs[k].exp_bad));
        if (vecs[k].exp_bad) begin
          clr_pulse();
          check("vec_err_clr", 32'(err_bad_unit), 32'(0));
        end
      end
    end

    // Busy wait: second packet to unit 7 holds until done, then issues 2 cycles later
    exp_q.push_back(20'h07408);
    send(24'h07_10_00);
    step();
    exp_q.push_back(20'h07959);
    send(24'h07_24_51);
    for (int i = 0; i < 4; i++) begin
      step();
      check("wait_no_vld", 32'(cmd_valid), 32'(0));
    end
    done_pulse(8'd7);
    check("wait_n1_no_vld", 32'(cmd_valid), 32'(0));
    step();
    check("wait_n2_vld", 32'(cmd_valid), 32'(1));
    step();
    exp_cnt += 2;
    check("wait_cnt", 32'(issue_cnt), 32'(exp_cnt));
    check("wait_busy", 32'(busy_map), 32'(16'h0080));
    done_pulse(8'd7);

    // Spurious done: idle unit, illegal unit, clear colliding with a new error
    done_pulse(8'd9);
    check("spur_idle", 32'(err_spurious), 32'(1));
    check("spur_busy_unch", 32'(busy_map), 32'(0));
    clr_pulse();
    check("spur_clr", 32'(err_spurious), 32'(0));
    done_pulse(8'd20);
    check("spur_illegal", 32'(err_spurious), 32'(1));
    err_clr = 1'b1;
    done_pulse(8'd9);
    err_clr = 1'b0;
    check("spur_clr_vs_new", 32'(err_spurious), 32'(1));
    clr_pulse();
    check("spur_clr2", 32'(err_spurious), 32'(0));

    // Done for unit 2 in the same cycle as its issue handshake: set wins
    cmd_ready = 1'b0;
    exp_q.push_back(20'h0253D);
    send(24'h02_14_35);
    step();
    check("sim_vld", 32'(cmd_valid), 32'(1));
    cmd_ready = 1'b1;
    done_pulse(8'd2);
    exp_cnt++;
    check("sim_busy_set_wins", 32'(busy_map), 32'(16'h0004));
    check("sim_spur", 32'(err_spurious), 32'(1));
    clr_pulse();
    done_pulse(8'd2);
    check("sim_busy_clr", 32'(busy_map), 32'(0));

    // Backpressure: command stable for 10 stalled cycles
    cmd_ready = 1'b0;
    exp_q.push_back(20'h047CE);
    send(24'h04_1C_C6);
    step();
    for (int i = 0; i < 10; i++) begin
      check("bp_vld", 32'(cmd_valid), 32'(1));
      check("bp_cmd", 32'(cmd), 32'(20'h047CE));
      step();
    end
    cmd_ready = 1'b1;
    step();
    exp_cnt++;
    check("bp_cnt", 32'(issue_cnt), 32'(exp_cnt));
    done_pulse(8'd4);

    // Reset in the middle of ISSUE drops the command and clears everything
    send(24'h1E_14_00);
    step();
    check("rst_pre_bad", 32'(err_bad_unit), 32'(1));
    cmd_ready = 1'b0;
    send(24'h06_14_35);
    step();
    check("rst_pre_vld", 32'(cmd_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(cmd_valid), 32'(0));
    check("mid_rst_cmd", 32'(cmd), 32'(0));
    check("mid_rst_rdy", 32'(pkt_ready), 32'(0));
    check("mid_rst_busy", 32'(busy_map), 32'(0));
    check("mid_rst_cnt", 32'(issue_cnt), 32'(0));
    check("mid_rst_errs", 32'({err_bad_unit, err_spurious}), 32'(0));
    step();
    step();
    rst_n = 1'b1;
    exp_cnt = 0;
    step();
    check("rel_pkt_ready", 32'(pkt_ready), 32'(1));
    cmd_ready = 1'b1;
    exp_q.push_back(20'h0653D);
    send(24'h06_14_35);
    step();
    check("after_rst_vld", 32'(cmd_valid), 32'(1));
    step();
    exp_cnt++;
    check("after_rst_cnt", 32'(issue_cnt), 32'(exp_cnt));
    check("after_rst_busy", 32'(busy_map), 32'(16'h0040));

    step();
    check("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/accel_dispatcher.md
# accel_dispatcher

Single-issue control dispatcher between the host control-packet stream and the accelerator unit array. It accepts raw `ctrl_packet_t` packets over a valid/ready handshake and decodes them into `decoded_ctrl_t`. It holds each command until the target unit is idle, then issues it downstream. A per-unit busy scoreboard (set on issue, cleared on unit-done) serialises commands to the same unit and flags protocol errors.

## Interface
Parameters:
- `NUM_UNITS`, default `UNIT_COUNT` (256): number of populated units; IDs ≥ NUM_UNITS are illegal.
- `CNT_WIDTH`, default 16: width of the issue counter.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pkt_valid`  in  1  input packet valid.
- `pkt_ready`  out  1  dispatcher can accept a packet.
- `pkt`  in  `$bits(ctrl_packet_t)`  raw control packet.
- `cmd_valid`  out  1  decoded command valid.
- `cmd_ready`  in  1  downstream accepts the command.
- `cmd`  out  `$bits(decoded_ctrl_t)`  decoded command.
- `done_valid`  in  1  a unit reports completion.
- `done_id`  in  `UNIT_ID_WIDTH`  ID of the completing unit.
- `busy_map`  out  `NUM_UNITS`  scoreboard; bit i is 1 while unit i is busy.
- `issue_cnt`  out  `CNT_WIDTH`  count of commands issued; wraps.
- `err_bad_unit`  out  1  sticky: a packet addressed an illegal unit.
- `err_spurious`  out  1  sticky: `done` was received for a non-busy or illegal unit.
- `err_clr`  in  1  synchronous clear of both error flags.

## Operation
Decode, purely combinational from the latched packet:
- `unit_id` = `pkt.unit_id`
- `op_code` = `ctrl[5:4]`
- `comp_type` = `ctrl[3:2]`
- `ctrl[1:0]` is reserved and ignored.
- `addr` = `config[7:4]`
- `size` = `config[2:0]`
- `config[3]` is reserved.
- `valid` = (`op_code` ≠ `OP_NOP`).

FSM states: IDLE, DECODE, WAIT_UNIT, ISSUE.
- **IDLE:** `pkt_ready`=1. When `pkt_valid` is high, latch `pkt` → DECODE.
- **DECODE:**
  - op = NOP → discard → IDLE. The NOP is not counted.
  - `unit_id` ≥ NUM_UNITS → set `err_bad_unit`, discard → IDLE.
  - `busy_map[unit_id]`=1 → WAIT_UNIT.
  - otherwise → ISSUE.
- **WAIT_UNIT:** stay until `busy_map[unit_id]`=0, then → ISSUE. There is no timeout.
- **ISSUE:** `cmd_valid`=1 and `cmd` is held stable. When `cmd_ready` is high:
  - set `busy_map[unit_id]`
  - increment `issue_cnt` (modulo 2^CNT_WIDTH)
  - → IDLE.

Scoreboard:
- `done_valid` with a legal, busy `done_id` clears that bit.
- A `done` for a non-busy or illegal ID leaves `busy_map` unchanged and sets `err_spurious`.
- Clear and set on the same bit in the same cycle: the set wins.
- A `done` in WAIT_UNIT for the waited unit is seen the next cycle, so ISSUE follows one cycle later.

Errors:
- Error flags are sticky until `err_clr`.
- `err_clr` coincident with a new error: the error wins (flag stays 1).

Reset (`rst_n`=0, any time including mid-ISSUE):
- FSM → IDLE.
- `busy_map`=0, `issue_cnt`=0, both error flags = 0.
- `cmd_valid`=0, `cmd`=0, `pkt_ready`=0 while in reset; `pkt_ready`=1 from the first clock after release.
- Any in-flight command is dropped.

## Timing
- Packet accepted at edge 0 → DECODE in cycle 1 → earliest `cmd_valid` in cycle 2.
- Minimum three cycles per packet, so throughput ≤ 1 packet per 3 cycles.
- `pkt_ready` is a registered function of state and is high only in IDLE.
- `cmd_valid` and `cmd` come directly from registers.
- Once asserted, `cmd_valid` stays high until the handshake completes; no retraction.
- `busy_map` and the error flags update on the edge after the causing event.

## Structure
- Add to `accel_pkg`:
  - a `disp_state_e` enum (IDLE, DECODE, WAIT_UNIT, ISSUE)
  - a `decode_ctrl()` function mapping `ctrl_packet_t` → `decoded_ctrl_t`, shared with any other decoder.
- Reuse `UNIT_COUNT` and `UNIT_ID_WIDTH` from `accel_pkg`.
- One sub-module, `unit_scoreboard`, holds `busy_map`, the set/clear priority and spurious-done detection. It takes parameter `NUM_UNITS`.

## Test plan
- **Basic issue:** after reset, send unit 5 / COMPUTE / MUL, `config`=8'h35.
  - `cmd` = {5, OP_COMPUTE, COMP_MUL, addr 3, valid 1, size 5} in cycle 2.
  - With `cmd_ready`=1: `busy_map[5]`=1, `issue_cnt`=1.
- **NOP:** send a NOP packet → no `cmd_valid`; `issue_cnt` unchanged; `pkt_ready` high again in cycle 2.
- **Busy wait:** two back-to-back packets to unit 7.
  - The second holds in WAIT_UNIT.
  - `done_valid`/`done_id`=7 at cycle N → second `cmd_valid` at cycle N+2.
- **Illegal unit:** with `NUM_UNITS`=16, send unit 20 → `err_bad_unit`=1, no issue; `err_clr` → 0.
- **Spurious and simultaneous done:**
  - `done_id`=9 while unit 9 is idle → `err_spurious`=1.
  - `done` for unit 2 in the same cycle as the issue handshake for unit 2 → `busy_map[2]`=1.
- **Backpressure and reset:**
  - Hold `cmd_ready`=0 for 10 cycles → `cmd` stable throughout.
  - Assert `rst_n`=0 mid-ISSUE → all outputs 0; the next packet is issued normally.
